fwft_fifo: RTL
==============

# fwft_fifo

Single-clock first-word-fall-through FIFO controller that owns the team's dual-port `sram` macro and wraps it with valid/ready handshakes on both sides. It generates write/read pointers, tracks occupancy, and hides the SRAM's one-cycle registered read latency behind a 2-entry output buffer. Producers see a plain FIFO with sustained one-word-per-cycle throughput, and consumers see a FIFO whose head word is always presented on `out_data`. It is the buffering stage placed in front of every `sram` instance in the MMU datapath.

## Interface
- `ADDR_WIDTH`, 6: SRAM address width; SRAM depth `DEPTH = 1<<ADDR_WIDTH`.
- `DATA_WIDTH`, 64: word width.
- `AFULL_LEVEL`, `DEPTH-2`: `almost_full` asserts when `count >= AFULL_LEVEL`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous clear; has priority over push/pop.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  FIFO accepts; `= !sram_full && !flush`.
- `in_data`  in  DATA_WIDTH  pushed word.
- `out_valid`  out  1  head word present.
- `out_ready`  in  1  consumer takes head.
- `out_data`  out  DATA_WIDTH  head word; stable while `out_valid && !out_ready`.
- `count`  out  ADDR_WIDTH+2  total words held (SRAM + in-flight read + buffer); max `DEPTH+2`.
- `almost_full`  out  1  registered threshold flag.

## Operation
- Push = `in_valid && in_ready`: write `in_data` at `wr_ptr`; `wr_ptr` +1 mod DEPTH.
- Pop = `out_valid && out_ready`: drop head; buffer shifts.
- SRAM occupancy `sram_cnt` (ADDR_WIDTH+1 bits, 0..DEPTH); `sram_full = (sram_cnt == DEPTH)`.
- Read issue: `rd_en = (sram_cnt != 0) && (buf_cnt + inflight - pop < 2)`. On issue, `rd_ptr` +1, `sram_cnt` −1, `inflight` set for one cycle. Only entries whose write was already committed (`sram_cnt` is registered) are read, so the same-address read-during-write case never occurs.
- Output buffer: 2 entries, `buf_cnt` 0..2; the returning read word enters the first free slot after any pop shift.
- Push and issue in the same cycle: `sram_cnt` unchanged. Push while `sram_full`: blocked by `in_ready = 0`.
- `count` = `sram_cnt + inflight + buf_cnt`, updated every cycle.
- `flush`: pointers, counts, `inflight`, `buf_cnt` → 0 at next edge. The push or pop in that cycle is discarded, and any read return in flight is dropped.
- Reset: identical to flush but asynchronous. During reset `out_valid = 0`, `count = 0`, `almost_full = 0`, and `in_ready = 1` (pointers are 0, so not full). SRAM contents are undefined and never read before being written.

## Timing
- Push accepted at edge k into empty FIFO: `rd_en` high in cycle k→k+1, and `out_valid` is high from edge k+1 (one-edge fall-through latency).
- Sustained: with `in_valid = out_ready = 1` continuously, one word per cycle in and out, no bubbles after the first.
- `in_ready` falls in the same cycle that `sram_cnt` reaches DEPTH, and rises one edge after the issuing read frees a slot.
- `almost_full` and `count` reflect state after the last edge, with no combinational path from inputs.
- Back-pressure: `out_ready = 0` holds `out_data`/`out_valid`. The buffer fills to 2, then reads stop and the SRAM fills.
- Pointer wrap at DEPTH−1 → 0 is transparent, and order is preserved across the wrap.

## Structure
- Shared package `mmu_pkg`: `clog2` function, handshake-side enum if used elsewhere. No block-local typedefs are exported.
- One sub-module: `sram` (instance `u_sram`), with `wr_clk = rd_clk = clk`, driven by `wr_ptr`, `rd_ptr`, `rd_en`. Pointer/count logic and the 2-entry buffer stay in this module.

## Test plan
ADDR_WIDTH=2 (DEPTH 4, capacity 6), DATA_WIDTH=8, AFULL_LEVEL=2.
- Single push 0xA5 at edge k, `out_ready = 0` → `out_valid` high from k+1, `out_data = 0xA5`, `count = 1`, held stable for 5 cycles.
- Push 0x01..0x06 with `out_ready = 0` → `count` reaches 6, `in_ready = 0` after 6th push, 7th word not accepted, `almost_full = 1`. Then pop all six → 0x01..0x06 in order, `count = 0`, `out_valid = 0`.
- Continuous push 0x00..0x1F with `out_ready = 1` throughout → output 0x00..0x1F, one per cycle after the first, `count` never exceeds 2, pointers wrap 8 times.
- Random `in_valid`/`out_ready` (50%) for 2000 cycles → scoreboard order match, `count` equals scoreboard depth every cycle.
- `flush` asserted with `count = 5` and a read in flight → next cycle `count = 0`, `out_valid = 0`, `in_ready = 1`, and a subsequent push 0x7E is output as 0x7E.
- `rst_n` pulled low mid-stream between edges → outputs go to reset values immediately. After release, a push 0x33 appears with one-edge latency.

Source files
------------

// File: rtl/mmu_pkg.sv
// -----------------------------------------------------------------------------
// mmu_pkg
//
// Shared definitions for the MMU datapath blocks.
//
// Contents:
//   clog2      - constant function: ceil(log2(value)), clog2(1) = 0.
//                Used to size counters from the number of states they hold.
//   hs_side_e  - names the two handshake sides of a buffering stage
//                (write/producer side and read/consumer side).
// -----------------------------------------------------------------------------
package mmu_pkg;

    typedef enum logic {
        HS_SIDE_WR = 1'b0,
        HS_SIDE_RD = 1'b1
    } hs_side_e;

    // Number of bits needed to encode 'value' distinct states.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : mmu_pkg

// File: rtl/sram.sv
// -----------------------------------------------------------------------------
// sram
//
// Simple dual-port SRAM model: one write port, one read port with a
// registered output (read data appears one rd_clk edge after rd_en).
// rd_data holds its value whenever rd_en is low.
//
// Ports:
//   wr_clk   in   write clock
//   wr_en    in   write strobe
//   wr_addr  in   [ADDR_WIDTH-1:0] write address
//   wr_data  in   [DATA_WIDTH-1:0] write data
//   rd_clk   in   read clock
//   rd_en    in   read strobe; loads rd_data from rd_addr
//   rd_addr  in   [ADDR_WIDTH-1:0] read address
//   rd_data  out  [DATA_WIDTH-1:0] registered read data
//
// A read and write to the same address in the same cycle returns the old
// contents; callers that care must avoid that case.
// -----------------------------------------------------------------------------
module sram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  wr_clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_clk,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays and their read register carry no reset; a reset
    // would turn the array into flops and the contents are never read
    // before being written anyway.
    always_ff @(posedge wr_clk) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values regardless of statement order.
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : sram

// File: rtl/fwft_fifo.sv
// -----------------------------------------------------------------------------
// fwft_fifo
//
// Single-clock first-word-fall-through FIFO built around one sram instance.
// The SRAM's one-cycle registered read is hidden behind a 2-entry output
// buffer, so the head word is always presented on out_data and sustained
// one-word-per-cycle throughput is possible in both directions.
//
// Storage stages, oldest first:
//   buffer (0..2 words) -> in-flight read (SRAM output register, 0..1 word)
//   -> SRAM array (0..DEPTH words)
// A word in the in-flight stage is already visible on out_data, which gives
// a one-edge fall-through latency from push to out_valid.
//
// Parameters:
//   ADDR_WIDTH   SRAM address width, DEPTH = 1 << ADDR_WIDTH
//   DATA_WIDTH   word width
//   AFULL_LEVEL  almost_full asserts when count >= AFULL_LEVEL
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous clear, overrides push/pop
//   in_valid     in   producer has a word
//   in_ready     out  FIFO accepts a word (SRAM not full and no flush)
//   in_data      in   [DATA_WIDTH-1:0] pushed word
//   out_valid    out  head word present
//   out_ready    in   consumer takes the head word
//   out_data     out  [DATA_WIDTH-1:0] head word
//   count        out  [ADDR_WIDTH+1:0] words held in all stages (max DEPTH+2)
//   almost_full  out  registered count >= AFULL_LEVEL
// -----------------------------------------------------------------------------
module fwft_fifo
    import mmu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 64,
    parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  almost_full
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int SC_W      = ADDR_WIDTH + 1;          // sram_cnt: 0..DEPTH
    localparam int CNT_W     = ADDR_WIDTH + 2;          // count: 0..DEPTH+2
    localparam int BUF_DEPTH = 2;
    localparam int BUF_CNT_W = clog2(BUF_DEPTH + 1);    // buf_cnt: 0..2
    localparam int PEND_W    = BUF_CNT_W + 1;

    localparam logic [SC_W-1:0]   SRAM_FULL_CNT = SC_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AFULL_CNT     = CNT_W'(AFULL_LEVEL);
    localparam logic [PEND_W-1:0] PEND_LIMIT    = PEND_W'(BUF_DEPTH);

    // Pointer / occupancy state
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [SC_W-1:0]       sram_cnt;
    logic [SC_W-1:0]       sram_cnt_next;
    logic                  inflight;

    // Output buffer: head_q is the oldest buffered word, tail_q the next
    logic [BUF_CNT_W-1:0]  buf_cnt;
    logic [BUF_CNT_W-1:0]  buf_cnt_next;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [DATA_WIDTH-1:0] head_next;
    logic [DATA_WIDTH-1:0] tail_next;

    logic [CNT_W-1:0]      count_next;
    logic [PEND_W-1:0]     pending;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  sram_full;
    logic                  buf_empty;
    logic                  push;
    logic                  pop;
    logic                  rd_en;
    logic                  take_return;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign sram_full = (sram_cnt == SRAM_FULL_CNT);
    assign in_ready  = !sram_full && !flush;
    assign push      = in_valid && in_ready;

    // The in-flight read is the head whenever the buffer is empty, so a word
    // is visible the cycle after its read was issued.
    assign buf_empty = (buf_cnt == '0);
    assign out_valid = !buf_empty || inflight;
    assign out_data  = buf_empty ? rd_data : head_q;
    assign pop       = out_valid && out_ready;

    // Issue a read only if the word it returns will have a buffer slot.
    // buf_cnt + inflight never exceeds 2, and pop implies at least one of
    // them is non-zero, so this cannot underflow.
    assign pending = PEND_W'(buf_cnt) + PEND_W'(inflight) - PEND_W'(pop);
    assign rd_en   = !flush && (sram_cnt != '0) && (pending < PEND_LIMIT);

    // A returning word is dropped into the buffer unless it was consumed
    // straight off the SRAM output this cycle.
    assign take_return = inflight && !(pop && buf_empty);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        head_next    = head_q;
        tail_next    = tail_q;
        buf_cnt_next = buf_cnt;

        if (pop && !buf_empty) begin
            head_next    = tail_q;
            buf_cnt_next = buf_cnt - BUF_CNT_W'(1);
        end

        if (take_return) begin
            if (buf_cnt_next == '0) begin
                head_next = rd_data;
            end else begin
                tail_next = rd_data;
            end
            buf_cnt_next = buf_cnt_next + BUF_CNT_W'(1);
        end
    end

    // A simultaneous push and issue leaves sram_cnt unchanged.
    assign sram_cnt_next = sram_cnt + SC_W'(push) - SC_W'(rd_en);

    // Occupancy after the coming edge: an issued read moves into the
    // in-flight stage.
    assign count_next = CNT_W'(sram_cnt_next) + CNT_W'(rd_en) + CNT_W'(buf_cnt_next);

    // Reported occupancy is a pure function of registered state.
    assign count = CNT_W'(sram_cnt) + CNT_W'(inflight) + CNT_W'(buf_cnt);

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sram_cnt    <= '0;
            inflight    <= 1'b0;
            buf_cnt     <= '0;
            almost_full <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sram_cnt    <= '0;
            inflight    <= 1'b0;
            buf_cnt     <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + ADDR_WIDTH'(push);
            rd_ptr      <= rd_ptr + ADDR_WIDTH'(rd_en);
            sram_cnt    <= sram_cnt_next;
            inflight    <= rd_en;
            buf_cnt     <= buf_cnt_next;
            almost_full <= (count_next >= AFULL_CNT);
        end
    end

    // Buffer data is qualified by buf_cnt, so it needs no reset or flush.
    always_ff @(posedge clk) begin
        head_q <= head_next;
        tail_q <= tail_next;
    end

    // -------------------------------------------------------------------------
    // Storage. Reads only target entries counted in the registered sram_cnt,
    // so a read never hits the address being written in the same cycle.
    // -------------------------------------------------------------------------
    sram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sram (
        .wr_clk  (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_clk  (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule : fwft_fifo
